elastic_pipe_register: RTL and testbench

ELASTIC_PIPE_REGISTER -- requirements
Module: elastic_pipe_register

---
 rtl/elastic_pipe_register_pkg.sv | 26 ++
 rtl/elastic_pipe_register_slot.sv | 21 ++
 rtl/elastic_pipe_register.sv | 115 +++++++++++
 tb/tb_elastic_pipe_register.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/elastic_pipe_register_pkg.sv
// Shared definitions for the two-entry elastic pipeline register:
// occupancy encoding, slot indices and default bubble payloads.
package elastic_pipe_register_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam logic [15:0] BUBBLE_INST_DEF = 16'h2000;  // xor $0,$0,$0
  localparam logic [15:0] BUBBLE_PC_DEF   = 16'h0000;

  localparam int NUM_SLOTS = 2;
  localparam int SLOT_MAIN = 0;
  localparam int SLOT_SKID = 1;

  function automatic logic st_can_accept(pipe_state_e s);
    return s != ST_TWO;
  endfunction

  function automatic logic st_has_head(pipe_state_e s);
    return s != ST_EMPTY;
  endfunction

endpackage

// File: rtl/elastic_pipe_register_slot.sv
// One payload entry: load-enable register that resets and clears to a bubble.
module pipe_slot #(
  parameter int           W      = 32,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // clr wins over ld so a flush discards a same-cycle load
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= BUBBLE;
    else if (clr) q <= BUBBLE;
    else if (ld)  q <= d;
  end

endmodule

// File: rtl/elastic_pipe_register.sv
// Fetch->decode elastic register: main entry drives outputs, skid entry absorbs
// one beat of backpressure so in_ready depends only on registered state.
module elastic_pipe_register
  import elastic_pipe_register_pkg::*;
#(
  parameter int                INST_W      = 16,
  parameter int                PC_W        = 16,
  parameter int                CNT_W       = 16,
  parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(BUBBLE_INST_DEF),
  parameter logic [PC_W-1:0]   BUBBLE_PC   = PC_W'(BUBBLE_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int                SLOT_W      = INST_W + PC_W;
  localparam logic [SLOT_W-1:0] SLOT_BUBBLE = {BUBBLE_INST, BUBBLE_PC};

  pipe_state_e state_q, state_d;
  logic        in_fire, out_fire;
  logic        main_from_skid;

  logic [NUM_SLOTS-1:0]             slot_ld, slot_clr;
  logic [NUM_SLOTS-1:0][SLOT_W-1:0] slot_d, slot_q;

  assign in_ready  = st_can_accept(state_q);
  assign out_valid = st_has_head(state_q);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_d = ST_TWO;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_TWO:   if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Entries are cleared whenever they are vacated, so a stale payload never
  // lingers in a slot that the state says is empty.
  always_comb begin
    slot_ld        = '0;
    slot_clr       = {NUM_SLOTS{flush}};
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: slot_ld[SLOT_MAIN] = in_fire;
      ST_ONE: begin
        if (in_fire && out_fire) slot_ld[SLOT_MAIN]  = 1'b1;
        else if (in_fire)        slot_ld[SLOT_SKID]  = 1'b1;
        else if (out_fire)       slot_clr[SLOT_MAIN] = 1'b1;
      end
      ST_TWO: begin
        if (out_fire) begin
          slot_ld[SLOT_MAIN]  = 1'b1;
          main_from_skid      = 1'b1;
          slot_clr[SLOT_SKID] = 1'b1;
        end
      end
      default: slot_clr = '1;
    endcase
  end

  assign slot_d[SLOT_MAIN] = main_from_skid ? slot_q[SLOT_SKID] : {in_inst, in_pc};
  assign slot_d[SLOT_SKID] = {in_inst, in_pc};

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    pipe_slot #(
      .W      (SLOT_W),
      .BUBBLE (SLOT_BUBBLE)
    ) u_slot (
      .clk (clk),
      .rst (rst),
      .clr (slot_clr[g]),
      .ld  (slot_ld[g]),
      .d   (slot_d[g]),
      .q   (slot_q[g])
    );
  end

  // Gate on out_valid as well, so outputs are bubbles even if main is not.
  assign out_inst = out_valid ? slot_q[SLOT_MAIN][SLOT_W-1:PC_W] : BUBBLE_INST;
  assign out_pc   = out_valid ? slot_q[SLOT_MAIN][PC_W-1:0]      : BUBBLE_PC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_elastic_pipe_register.sv
// Directed bench for elastic_pipe_register: default config plus a CNT_W=4
// instance used only for stall-counter saturation.
module tb_elastic_pipe_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] in_inst, in_pc, out_inst, out_pc, stall_cnt;

  logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
  logic [15:0] s_in_inst, s_in_pc, s_out_inst, s_out_pc;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elastic_pipe_register dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .stall_cnt(stall_cnt)
  );

  elastic_pipe_register #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_inst(s_in_inst), .in_pc(s_in_pc), .flush(s_flush), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_inst(s_out_inst), .out_pc(s_out_pc),
    .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] inst,
                         input logic [15:0] pc);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".inst"},  32'(out_inst),  32'(inst));
    chk({tag, ".pc"},    32'(out_pc),    32'(pc));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_inst = '0; s_in_pc = '0; s_flush = 1'b0; s_out_ready = 1'b0;

    // reset values while rst is held
    #2;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk_out("rst", 1'b0, 16'h2000, 16'h0000);
    chk("rst.stall", 32'(stall_cnt), 32'd0);
    #10 rst = 1'b0;
    tick();
    chk("idle.in_ready", 32'(in_ready), 32'd1);
    chk_out("idle", 1'b0, 16'h2000, 16'h0000);
    chk("idle.stall", 32'(stall_cnt), 32'd0);

    // streaming: one cycle latency, one beat per cycle
    out_ready = 1'b1; in_valid = 1'b1;
    in_inst = 16'h1111; in_pc = 16'h0002; tick(); chk_out("s1", 1'b1, 16'h1111, 16'h0002);
    in_inst = 16'h1112; in_pc = 16'h0004; tick(); chk_out("s2", 1'b1, 16'h1112, 16'h0004);
    in_inst = 16'h1113; in_pc = 16'h0006; tick(); chk_out("s3", 1'b1, 16'h1113, 16'h0006);
    in_inst = 16'h1114; in_pc = 16'h0008; tick(); chk_out("s4", 1'b1, 16'h1114, 16'h0008);
    chk("s4.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0; in_inst = 16'hdead; tick();
    chk_out("s.drain", 1'b0, 16'h2000, 16'h0000);
    chk("s.stall", 32'(stall_cnt), 32'd0);

    // backpressure into TWO, refused third beat, ordered release
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 16'h1111; in_pc = 16'h0010; tick();
    chk_out("bp1", 1'b1, 16'h1111, 16'h0010);
    chk("bp1.stall", 32'(stall_cnt), 32'd0);
    in_inst = 16'h2222; in_pc = 16'h0012; tick();
    chk("bp2.in_ready", 32'(in_ready), 32'd0);
    chk_out("bp2", 1'b1, 16'h1111, 16'h0010);
    chk("bp2.stall", 32'(stall_cnt), 32'd1);
    in_inst = 16'h3333; in_pc = 16'h0014; tick();
    chk("bp3.in_ready", 32'(in_ready), 32'd0);
    chk_out("bp3", 1'b1, 16'h1111, 16'h0010);
    tick();
    chk("bp4.stall", 32'(stall_cnt), 32'd3);
    out_ready = 1'b1; tick();
    chk_out("bp.rel1", 1'b1, 16'h2222, 16'h0012);
    chk("bp.rel1.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("bp.rel2", 1'b1, 16'h3333, 16'h0014);
    in_valid = 1'b0; tick();
    chk_out("bp.drain", 1'b0, 16'h2000, 16'h0000);
    chk("bp.stall", 32'(stall_cnt), 32'd3);

    // flush while TWO, with 4444 offered at the same time
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 16'ha001; in_pc = 16'h0020; tick();
    in_inst = 16'ha002; in_pc = 16'h0022; tick();
    chk("fl.two.in_ready", 32'(in_ready), 32'd0);
    in_inst = 16'h4444; in_pc = 16'h0024; flush = 1'b1; tick();
    chk_out("fl.two", 1'b0, 16'h2000, 16'h0000);
    chk("fl.two.in_ready", 32'(in_ready), 32'd1);
    chk("fl.two.stall", 32'(stall_cnt), 32'd5);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    chk_out("fl.two.after", 1'b0, 16'h2000, 16'h0000);

    // flush while ONE with a real in_fire of 4444: payload discarded
    in_valid = 1'b1; in_inst = 16'hb001; in_pc = 16'h0030; tick();
    chk_out("fl.one", 1'b1, 16'hb001, 16'h0030);
    in_inst = 16'h4444; in_pc = 16'h0032; flush = 1'b1; tick();
    chk_out("fl.one.flush", 1'b0, 16'h2000, 16'h0000);
    flush = 1'b0; in_valid = 1'b0; tick();
    chk_out("fl.one.after", 1'b0, 16'h2000, 16'h0000);
    chk("fl.stall", 32'(stall_cnt), 32'd5);

    // async reset mid-cycle while ONE
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 16'h5555; in_pc = 16'h0040; tick();
    in_valid = 1'b0;
    chk_out("ar.pre", 1'b1, 16'h5555, 16'h0040);
    #2 rst = 1'b1;
    #1;
    chk_out("ar.mid", 1'b0, 16'h2000, 16'h0000);
    chk("ar.in_ready", 32'(in_ready), 32'd1);
    chk("ar.stall", 32'(stall_cnt), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk_out("ar.after", 1'b0, 16'h2000, 16'h0000);

    // saturation on the 4-bit counter instance
    s_in_valid = 1'b1; s_in_inst = 16'h6666; s_in_pc = 16'h0050; tick();
    s_in_valid = 1'b0;
    chk("sat.start", 32'(s_stall_cnt), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("sat.5", 32'(s_stall_cnt), 32'd5);
    for (int i = 0; i < 15; i++) tick();
    chk("sat.20", 32'(s_stall_cnt), 32'd15);
    chk("sat.inst", 32'(s_out_inst), 32'h6666);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
